// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter_pkg
//  Purpose  : Shared state encoding and owner_o codes for the fifo write-side
//             arbiter and its round-robin picker.
//  Contents : arb_state_t   - ST_IDLE / ST_OWN0 / ST_OWN1
//             OWNER_*       - owner_o encodings
//             owner_code()  - maps a state to its owner_o value
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_IDLE  = 2'b00;
    localparam logic [1:0] OWNER_PORT0 = 2'b01;
    localparam logic [1:0] OWNER_PORT1 = 2'b10;

    function automatic logic [1:0] owner_code(input arb_state_t st);
        logic [1:0] code;
        code = OWNER_IDLE;
        case (st)
            ST_OWN0: code = OWNER_PORT0;
            ST_OWN1: code = OWNER_PORT1;
            default: code = OWNER_IDLE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Two-way round-robin pick, purely combinational. On a tie the
//             port that was NOT granted last wins.
//  Ports    : req0, req1  in   requests
//             last        in   1 = port1 was granted most recently
//             gnt0, gnt1  out  one-hot (or zero) grant
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
    import fifo_wr_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = req0 & (~req1 | last);
        gnt1 = req1 & (~req0 | ~last);
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Shares the write side of one fifo between two producers.
//             Ownership is granted round-robin; an owner keeps at most BURST
//             words per tenure while the other producer waits. fifo full
//             blocks all writes.
//  Ports    : clk, rst_n            clock, async active-low reset
//             req0_i/data0_i/ack0_o producer 0 handshake
//             req1_i/data1_i/ack1_o producer 1 handshake
//             fifo_full_i           backpressure from fifo full_o
//             fifo_write_o          to fifo write_i
//             fifo_data_o           to fifo data_i (0 when not writing)
//             owner_o               00 idle, 01 port0, 10 port1
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int BURST  = 4,
    parameter int CWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic [DWIDTH-1:0] data0_i,
    output logic              ack0_o,
    input  logic              req1_i,
    input  logic [DWIDTH-1:0] data1_i,
    output logic              ack1_o,
    input  logic              fifo_full_i,
    output logic              fifo_write_o,
    output logic [DWIDTH-1:0] fifo_data_o,
    output logic [1:0]        owner_o
);

    localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(BURST - 1);

    arb_state_t        state, state_nxt;
    logic [CWIDTH-1:0] cnt, cnt_nxt;
    logic              last_owner, last_owner_nxt;

    logic              pick0, pick1;
    logic              own_req, other_req;
    arb_state_t        other_st;

    // Only used from ST_IDLE; handovers from an owning state go straight to
    // the other port without consulting the picker.
    rr_pick2 u_pick (
        .req0 (req0_i),
        .req1 (req1_i),
        .last (last_owner),
        .gnt0 (pick0),
        .gnt1 (pick1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;     // port0 wins the first tie
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_owner_nxt = last_owner;
        own_req        = (state == ST_OWN1) ? req1_i : req0_i;
        other_req      = (state == ST_OWN1) ? req0_i : req1_i;
        other_st       = (state == ST_OWN1) ? ST_OWN0 : ST_OWN1;

        case (state)
            ST_IDLE: begin
                if (pick0) begin
                    state_nxt      = ST_OWN0;
                    cnt_nxt        = '0;
                    last_owner_nxt = 1'b0;
                end else if (pick1) begin
                    state_nxt      = ST_OWN1;
                    cnt_nxt        = '0;
                    last_owner_nxt = 1'b1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_req) begin
                    // Owner let go: hand over without an idle bubble.
                    cnt_nxt = '0;
                    if (other_req) begin
                        state_nxt      = other_st;
                        last_owner_nxt = (other_st == ST_OWN1);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (fifo_full_i) begin
                    // Full stalls everyone; tenure and count are frozen.
                    state_nxt = state;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (other_req) begin
                        state_nxt      = other_st;
                        last_owner_nxt = (other_st == ST_OWN1);
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Acks follow the registered state directly, so an async reset drops
    // them in the same cycle and the word on the bus is not written.
    always_comb begin
        ack0_o       = (state == ST_OWN0) & req0_i & ~fifo_full_i;
        ack1_o       = (state == ST_OWN1) & req1_i & ~fifo_full_i;
        fifo_write_o = ack0_o | ack1_o;
        fifo_data_o  = '0;
        if (ack0_o) begin
            fifo_data_o = data0_i;
        end else if (ack1_o) begin
            fifo_data_o = data1_i;
        end
        owner_o = owner_code(state);
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter. Stimulus pushes the
//             expected per-cycle response into a scoreboard queue; a monitor
//             on the falling edge pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int BURST = 4;

    typedef struct packed {
        logic          a0;
        logic          a1;
        logic [DW-1:0] data;
        logic [1:0]    owner;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, full;
    logic [DW-1:0] d0, d1;
    logic          ack0, ack1, fwrite;
    logic [DW-1:0] fdata;
    logic [1:0]    owner;

    int total = 0;
    int bad   = 0;

    exp_t          sb[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit            full_plan[$];
    bit            gaps      = 1'b0;
    bit            rand_full = 1'b0;

    // Reference model: who holds the write port, how many words the holder
    // has written in the current tenure, and which port was granted last.
    int m_owner;   // 0 nobody, 1 port0, 2 port1
    int m_words;
    int m_last;    // port index 0/1

    fifo_wr_arbiter #(.DWIDTH(DW), .BURST(BURST), .CWIDTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_i       (req0),
        .data0_i      (d0),
        .ack0_o       (ack0),
        .req1_i       (req1),
        .data1_i      (d1),
        .ack1_o       (ack1),
        .fifo_full_i  (full),
        .fifo_write_o (fwrite),
        .fifo_data_o  (fdata),
        .owner_o      (owner)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_owner = 0;
        m_words = 0;
        m_last  = 1;
    endfunction

    function automatic void m_grant(input int p);
        m_owner = p + 1;
        m_last  = p;
        m_words = 0;
    endfunction

    // Only the current holder may write, only with a word present, never when full.
    function automatic void m_outputs(input bit r0, input bit r1, input bit f,
                                      output bit a0, output bit a1);
        a0 = (m_owner == 1) && r0 && !f;
        a1 = (m_owner == 2) && r1 && !f;
    endfunction

    function automatic void m_advance(input bit r0, input bit r1, input bit f);
        int h;
        bit mine, other;
        if (m_owner == 0) begin
            if (r0 && r1)  m_grant(1 - m_last);
            else if (r0)   m_grant(0);
            else if (r1)   m_grant(1);
        end else begin
            h     = m_owner - 1;
            mine  = (h == 1) ? r1 : r0;
            other = (h == 1) ? r0 : r1;
            if (!mine) begin
                if (other) m_grant(1 - h);
                else begin
                    m_owner = 0;
                    m_words = 0;
                end
            end else if (!f) begin
                m_words++;
                if (m_words == BURST) begin
                    m_words = 0;
                    if (other) m_grant(1 - h);
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic cycle();
        bit   f, a0, a1;
        exp_t e;
        if (!req0 && q0.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            req0 = 1'b1;
            d0   = q0[0];
        end
        if (!req1 && q1.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            req1 = 1'b1;
            d1   = q1[0];
        end
        if (full_plan.size() > 0) f = full_plan.pop_front();
        else if (rand_full)       f = ($urandom_range(0, 4) == 0);
        else                      f = 1'b0;
        full = f;

        m_outputs(req0, req1, f, a0, a1);
        e.a0    = a0;
        e.a1    = a1;
        e.data  = a0 ? d0 : (a1 ? d1 : '0);
        e.owner = 2'(m_owner);
        sb.push_back(e);
        m_advance(req0, req1, f);

        @(posedge clk);
        #1;
        if (a0) begin
            void'(q0.pop_front());
            req0 = 1'b0;
        end
        if (a1) begin
            void'(q1.pop_front());
            req1 = 1'b0;
        end
    endtask

    // Monitor: one scoreboard entry per cycle, plus the full/write safety rule.
    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            if (ack0 !== mon_e.a0 || ack1 !== mon_e.a1 || fwrite !== (mon_e.a0 | mon_e.a1) ||
                fdata !== mon_e.data || owner !== mon_e.owner) begin
                bad++;
                $display("FAIL cycle t=%0t got ack0=%b ack1=%b wr=%b data=%h owner=%b exp ack0=%b ack1=%b wr=%b data=%h owner=%b",
                         $time, ack0, ack1, fwrite, fdata, owner,
                         mon_e.a0, mon_e.a1, mon_e.a0 | mon_e.a1, mon_e.data, mon_e.owner);
            end
        end
        if (rst_n) begin
            total++;
            if ((fwrite & full) !== 1'b0) begin
                bad++;
                $display("FAIL write_while_full t=%0t got wr=%b full=%b exp wr=0", $time, fwrite, full);
            end
        end
    end

    initial begin
        bit x0, x1;
        rst_n = 1'b0;
        full  = 1'b0;
        m_reset();

        // Reset with both requests held.
        for (int i = 0; i < 10; i++) begin
            q0.push_back(DW'(8'hA0 + i));
            q1.push_back(DW'(8'hB0 + i));
        end
        req0 = 1'b1; d0 = q0[0];
        req1 = 1'b1; d1 = q1[0];
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack0",  32'(ack0),   0);
        check("rst_ack1",  32'(ack1),   0);
        check("rst_write", 32'(fwrite), 0);
        check("rst_data",  32'(fdata),  0);
        check("rst_owner", 32'(owner),  0);
        rst_n = 1'b1;

        // Both held: idle grant cycle, then alternating blocks of BURST.
        repeat (24) cycle();

        // Single producer, three words, then back to idle.
        q0.push_back(8'h11); q0.push_back(8'h22); q0.push_back(8'h33);
        repeat (6) cycle();
        check("t2_idle_owner", 32'(owner), 0);

        // Full stall mid-tenure with port1 waiting.
        for (int i = 0; i < 8; i++) q0.push_back(DW'(8'hC0 + i));
        cycle();
        for (int i = 0; i < 4; i++) q1.push_back(DW'(8'hD0 + i));
        full_plan = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        repeat (20) cycle();

        // Port1 owner drops req after one word while port0 waits.
        q1.push_back(8'h51);
        cycle();
        q0.push_back(8'h61); q0.push_back(8'h62);
        repeat (6) cycle();

        // Async reset during a port1 tenure.
        for (int i = 0; i < 4; i++) q1.push_back(DW'(8'hE0 + i));
        cycle();
        cycle();
        for (int i = 0; i < 3; i++) q0.push_back(DW'(8'hF0 + i));
        req1 = 1'b1; d1 = q1[0];
        req0 = 1'b1; d0 = q0[0];
        full = 1'b0;
        m_outputs(req0, req1, full, x0, x1);
        #1;
        check("mid_ack1_before", 32'(ack1),   32'(x1));
        check("mid_wr_before",   32'(fwrite), 32'(x0 | x1));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_ack1_rst",  32'(ack1),   0);
        check("mid_wr_rst",    32'(fwrite), 0);
        check("mid_data_rst",  32'(fdata),  0);
        check("mid_owner_rst", 32'(owner),  0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) cycle();

        // Randomised traffic with gaps and random backpressure.
        gaps      = 1'b1;
        rand_full = 1'b1;
        for (int i = 0; i < 150; i++) begin
            q0.push_back(DW'($urandom));
            q1.push_back(DW'($urandom));
        end
        repeat (500) cycle();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
